// File: rtl/arp_pkg.sv
// Shared types and constants for the ARP control slice.
package arp_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTxReply,
    StWaitReply,
    StTxReq,
    StWaitReq,
    StWaitAns
  } arp_state_e;

  localparam logic        ARP_REQ   = 1'b0;
  localparam logic        ARP_REPLY = 1'b1;
  localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/arp_cache.sv
// Fully associative IP->MAC cache: registered lookup port, write-with-replace port,
// round-robin victim pointer used only when every entry is valid.
module arp_cache
  import arp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [31:0] wr_ip,
  input  logic [47:0] wr_mac,
  input  logic        lk_req,
  input  logic [31:0] lk_ip,
  output logic        lk_found,
  output logic        lk_ack,
  output logic        lk_hit,
  output logic [47:0] lk_mac
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  logic [DEPTH-1:0] valid_q;
  logic [31:0]      ip_q  [DEPTH];
  logic [47:0]      mac_q [DEPTH];
  logic [IdxW-1:0]  rr_q, rr_d;
  logic             ack_q, hit_q;
  logic [47:0]      out_mac_q;

  logic [47:0]      lk_sel_mac;
  logic             wr_match, have_free;
  logic [IdxW-1:0]  match_idx, free_idx, wr_idx;

  always_comb begin
    lk_found   = 1'b0;
    lk_sel_mac = '0;
    wr_match   = 1'b0;
    match_idx  = '0;
    have_free  = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i] && ip_q[i] == lk_ip) begin
        lk_found   = 1'b1;
        lk_sel_mac = mac_q[i];
      end
      if (valid_q[i] && ip_q[i] == wr_ip) begin
        wr_match  = 1'b1;
        match_idx = IdxW'(i);
      end
    end
    // Scan downwards so the lowest-numbered free entry wins.
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        have_free = 1'b1;
        free_idx  = IdxW'(i);
      end
    end
    wr_idx = wr_match ? match_idx : (have_free ? free_idx : rr_q);
    rr_d   = (wr_en && !wr_match && !have_free) ? rr_q + IdxW'(1) : rr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      rr_q      <= '0;
      ack_q     <= 1'b0;
      hit_q     <= 1'b0;
      out_mac_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ip_q[i]  <= '0;
        mac_q[i] <= '0;
      end
    end else begin
      ack_q     <= lk_req;
      hit_q     <= lk_req & lk_found;
      out_mac_q <= (lk_req && lk_found) ? lk_sel_mac : '0;
      rr_q      <= rr_d;
      if (wr_en) begin
        valid_q[wr_idx] <= 1'b1;
        ip_q[wr_idx]    <= wr_ip;
        mac_q[wr_idx]   <= wr_mac;
      end
    end
  end

  assign lk_ack = ack_q;
  assign lk_hit = hit_q;
  assign lk_mac = out_mac_q;

endmodule

// File: rtl/arp_ctrl.sv
// ARP control: auto-reply to requests, learn sender bindings, resolve UDP lookups
// with retried broadcast requests.
module arp_ctrl
  import arp_pkg::*;
#(
  parameter int unsigned CACHE_DEPTH  = 4,
  parameter int unsigned RETRY_CYCLES = 125_000_000,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic        gmii_tx_clk,
  input  logic        rst_n,
  input  logic        arp_rx_done,
  input  logic        arp_rx_type,
  input  logic [47:0] src_mac,
  input  logic [31:0] src_ip,
  input  logic        gmii_tx_done,
  output logic        arp_tx_en,
  output logic        arp_tx_type,
  output logic [47:0] des_mac,
  output logic [31:0] des_ip,
  input  logic        lookup_req,
  input  logic [31:0] lookup_ip,
  output logic        lookup_ack,
  output logic        lookup_hit,
  output logic [47:0] lookup_mac,
  output logic        resolve_fail
);

  localparam int unsigned TimerW = $clog2(RETRY_CYCLES);
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(RETRY_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

  arp_state_e        state_q, state_d;
  logic              reply_pend_q, reply_pend_d;
  logic [47:0]       rep_mac_q, rep_mac_d;
  logic [31:0]       rep_ip_q, rep_ip_d;
  logic              req_pend_q, req_pend_d;
  logic [31:0]       pend_ip_q, pend_ip_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              tx_type_q, tx_type_d;
  logic [47:0]       des_mac_q, des_mac_d;
  logic [31:0]       des_ip_q, des_ip_d;
  logic              fail_q, fail_d;

  logic lk_found, rx_req, ans_match, in_flight;

  arp_cache #(
    .DEPTH (CACHE_DEPTH)
  ) u_cache (
    .clk      (gmii_tx_clk),
    .rst_n    (rst_n),
    .wr_en    (arp_rx_done),
    .wr_ip    (src_ip),
    .wr_mac   (src_mac),
    .lk_req   (lookup_req),
    .lk_ip    (lookup_ip),
    .lk_found (lk_found),
    .lk_ack   (lookup_ack),
    .lk_hit   (lookup_hit),
    .lk_mac   (lookup_mac)
  );

  always_comb begin
    state_d      = state_q;
    reply_pend_d = reply_pend_q;
    rep_mac_d    = rep_mac_q;
    rep_ip_d     = rep_ip_q;
    req_pend_d   = req_pend_q;
    pend_ip_d    = pend_ip_q;
    timer_d      = timer_q;
    retry_d      = retry_q;
    tx_type_d    = tx_type_q;
    des_mac_d    = des_mac_q;
    des_ip_d     = des_ip_q;
    fail_d       = 1'b0;

    rx_req    = arp_rx_done && (arp_rx_type == ARP_REQ);
    ans_match = arp_rx_done && (arp_rx_type == ARP_REPLY) && req_pend_q && (src_ip == pend_ip_q);
    // A request has actually gone out for the current resolution.
    in_flight = req_pend_q && (retry_q != '0);

    // Timer saturates so a long reply detour still times out promptly afterwards.
    if (in_flight && timer_q != TimerMax) timer_d = timer_q + TimerW'(1);

    unique case (state_q)
      StIdle: begin
        if (reply_pend_q)    state_d = StTxReply;
        else if (req_pend_q) state_d = StTxReq;
      end
      StTxReply: state_d = StWaitReply;
      StWaitReply: begin
        if (gmii_tx_done) state_d = in_flight ? StWaitAns : StIdle;
      end
      StTxReq: begin
        retry_d = retry_q + RetryW'(1);
        state_d = StWaitReq;
      end
      StWaitReq: begin
        if (gmii_tx_done) begin
          timer_d = '0;
          state_d = StWaitAns;
        end
      end
      StWaitAns: begin
        if (!req_pend_q || ans_match) begin
          state_d = StIdle;
        end else if (reply_pend_q) begin
          state_d = StTxReply;
        end else if (timer_q == TimerMax) begin
          if (retry_q < RetryMax) begin
            state_d = StTxReq;
          end else begin
            fail_d     = 1'b1;
            req_pend_d = 1'b0;
            retry_d    = '0;
            state_d    = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Frame fields are loaded on entry so they are stable for the whole transmit strobe.
    if (state_d == StTxReply && state_q != StTxReply) begin
      tx_type_d    = ARP_REPLY;
      des_mac_d    = rep_mac_q;
      des_ip_d     = rep_ip_q;
      reply_pend_d = 1'b0;
    end else if (state_d == StTxReq && state_q != StTxReq) begin
      tx_type_d = ARP_REQ;
      des_mac_d = MAC_BCAST;
      des_ip_d  = pend_ip_q;
    end

    // Newest request wins the single pending-reply slot.
    if (rx_req) begin
      reply_pend_d = 1'b1;
      rep_mac_d    = src_mac;
      rep_ip_d     = src_ip;
    end

    if (ans_match) begin
      req_pend_d = 1'b0;
      retry_d    = '0;
    end else if (lookup_req && !lk_found && !req_pend_q) begin
      req_pend_d = 1'b1;
      pend_ip_d  = lookup_ip;
    end
  end

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      reply_pend_q <= 1'b0;
      rep_mac_q    <= '0;
      rep_ip_q     <= '0;
      req_pend_q   <= 1'b0;
      pend_ip_q    <= '0;
      timer_q      <= '0;
      retry_q      <= '0;
      tx_type_q    <= 1'b0;
      des_mac_q    <= '0;
      des_ip_q     <= '0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      reply_pend_q <= reply_pend_d;
      rep_mac_q    <= rep_mac_d;
      rep_ip_q     <= rep_ip_d;
      req_pend_q   <= req_pend_d;
      pend_ip_q    <= pend_ip_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      tx_type_q    <= tx_type_d;
      des_mac_q    <= des_mac_d;
      des_ip_q     <= des_ip_d;
      fail_q       <= fail_d;
    end
  end

  assign arp_tx_en    = (state_q == StTxReply) || (state_q == StTxReq);
  assign arp_tx_type  = tx_type_q;
  assign des_mac      = des_mac_q;
  assign des_ip       = des_ip_q;
  assign resolve_fail = fail_q;

endmodule

// File: doc/arp_ctrl.md
# arp_ctrl

ARP control stage sitting directly beside the `arp` block in the GMII TX clock domain. It consumes `arp_rx_done`, `arp_rx_type`, `src_mac` and `src_ip`, and produces `arp_tx_en`, `arp_tx_type`, `des_mac` and `des_ip`. It answers incoming ARP requests automatically and learns sender bindings into a small IP→MAC cache. It also serves one-cycle cache lookups for the UDP path, issuing and retrying ARP requests on a miss.

## Interface
- `CACHE_DEPTH`, 4: number of cache entries (power of two, ≥2).
- `RETRY_CYCLES`, 125_000_000: cycles to wait for an answer before re-requesting (1 s at 125 MHz).
- `MAX_RETRY`, 3: request transmissions before giving up.
- `gmii_tx_clk`  in  1  sole clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `arp_rx_done`  in  1  one-cycle pulse: an ARP frame was received.
- `arp_rx_type`  in  1  0 = request, 1 = reply; valid with `arp_rx_done`.
- `src_mac`  in  48  sender MAC; valid with `arp_rx_done`.
- `src_ip`  in  32  sender IP; valid with `arp_rx_done`.
- `gmii_tx_done`  in  1  one-cycle pulse: `arp` finished transmitting.
- `arp_tx_en`  out  1  one-cycle transmit strobe to `arp`.
- `arp_tx_type`  out  1  0 = request, 1 = reply.
- `des_mac`  out  48  target MAC for the transmitted frame.
- `des_ip`  out  32  target IP for the transmitted frame.
- `lookup_req`  in  1  one-cycle lookup strobe from the UDP side.
- `lookup_ip`  in  32  IP to resolve; valid with `lookup_req`.
- `lookup_ack`  out  1  one-cycle response pulse.
- `lookup_hit`  out  1  1 = entry found; valid with `lookup_ack`.
- `lookup_mac`  out  48  resolved MAC; valid when `lookup_hit` = 1.
- `resolve_fail`  out  1  one-cycle pulse: `MAX_RETRY` requests went unanswered.

## Operation

**Reset values.** All outputs reset to 0, including `des_mac` and `des_ip`. All cache valid bits reset to 0, the FSM resets to IDLE, and all counters reset to 0.

**Learning.**
- Every `arp_rx_done` (request or reply) writes {`src_ip`, `src_mac`} into the cache.
- If `src_ip` matches a valid entry, that entry is overwritten in place.
- Otherwise the first invalid entry is used; if none is invalid, the round-robin replacement pointer selects the entry, and the pointer then increments modulo `CACHE_DEPTH`.

**Auto-reply.**
- An `arp_rx_done` with `arp_rx_type` = 0 sets `reply_pend` and latches the requester's MAC and IP.
- There is one pending slot. A later request overwrites it, so the newest request wins.

**Lookup.**
- `lookup_req` at cycle N produces `lookup_ack` at N+1, with `lookup_hit` and `lookup_mac` driven from the cache state at cycle N.
- On a miss with no resolution in progress, `pend_ip` ← `lookup_ip` and `req_pend` is set.
- A miss while a resolution is already in progress is only acknowledged; no new request is issued.

**FSM.** States are IDLE, TX_REPLY, WAIT_REPLY, TX_REQ, WAIT_REQ, WAIT_ANS.
- IDLE → TX_REPLY when `reply_pend`; otherwise IDLE → TX_REQ when `req_pend`. Replies have priority.
- TX_REPLY: `arp_tx_en` = 1, `arp_tx_type` = 1, `des_mac`/`des_ip` = latched requester, `reply_pend` cleared → WAIT_REPLY.
- WAIT_REPLY, on `gmii_tx_done`: → WAIT_ANS if `req_pend`, else → IDLE.
- TX_REQ: `arp_tx_en` = 1, `arp_tx_type` = 0, `des_mac` = ff:ff:ff:ff:ff:ff, `des_ip` = `pend_ip`, retry count incremented → WAIT_REQ.
- WAIT_REQ, on `gmii_tx_done`: wait timer cleared → WAIT_ANS.
- WAIT_ANS, each cycle:
  - A reply from `pend_ip` (`arp_rx_done`, type 1, `src_ip` == `pend_ip`) clears `req_pend` and the retry count → IDLE.
  - Else if `reply_pend` → TX_REPLY. The wait timer keeps running during the reply.
  - Else if the timer reaches `RETRY_CYCLES`−1: → TX_REQ when retries < `MAX_RETRY`; otherwise pulse `resolve_fail`, clear `req_pend` → IDLE.

## Timing
- `arp_tx_en` is high for exactly one cycle, on the cycle after entry into TX_REPLY or TX_REQ.
- `des_mac`, `des_ip` and `arp_tx_type` are registered and held from `arp_tx_en` until the cycle after `gmii_tx_done`.
- A second `arp_tx_en` never occurs before `gmii_tx_done` of the previous frame.
- Latency from request `arp_rx_done` to the reply's `arp_tx_en` is 2 cycles when the FSM is idle.
- Simultaneous `arp_rx_done` and `lookup_req` on the same IP: the lookup sees the pre-write cache (miss), and the write commits that cycle.
- A matching reply that arrives while in TX_REPLY or WAIT_REPLY still clears `req_pend`; the FSM then returns to IDLE.
- `rst_n` asserted mid-frame drops `arp_tx_en` immediately; all state is lost.

## Structure
- Package `arp_pkg`:
  - FSM state enum.
  - `ARP_REQ` = 1'b0, `ARP_REPLY` = 1'b1.
  - `MAC_BCAST` = 48'hFFFF_FFFF_FFFF.
- Sub-module `arp_cache`: fully associative storage, parallel IP compare, registered lookup port, write-with-replace port, round-robin pointer.
- `arp_ctrl` contains the FSM, pending flags, the wait timer (`$clog2(RETRY_CYCLES)` bits) and the retry counter (`$clog2(MAX_RETRY+1)` bits).

## Test plan
- **Auto-reply.** Request from 192.168.0.3 / 00:aa:bb:cc:dd:ee → `arp_tx_en` after 2 cycles with type 1 and `des_mac` = 00:aa:bb:cc:dd:ee. A subsequent lookup of 192.168.0.3 returns hit with that MAC.
- **Miss and resolve.** Lookup of 192.168.0.9 → `lookup_ack` with hit = 0, then a broadcast request with `des_ip` = 192.168.0.9. Injecting a reply from .9 / 02:00:00:00:00:09 returns the FSM to IDLE, and a relookup hits.
- **Timeout.** With `RETRY_CYCLES` = 100 and no answer → exactly 3 requests spaced about 100 cycles after each `gmii_tx_done`, then one `resolve_fail` pulse.
- **Reply pre-empts wait.** A request arrives during WAIT_ANS → reply sent, FSM returns to WAIT_ANS, and the retry schedule is unchanged.
- **Eviction.** Learning 5 distinct IPs with `CACHE_DEPTH` = 4 evicts the first-learned IP; relearning an existing IP updates its MAC without consuming a slot.
- **Reset mid-operation.** `rst_n` low during WAIT_REQ → all outputs 0, cache empty, and no transmit after release.
